// File: rtl/cpu_consts.sv
// Shared CPU constants: branch-predictor counter type and encodings,
// gshare FSM state enum, and the PHT write-port operation set.
package cpu_consts;

   // 2-bit saturating branch counter; bit 1 is the predicted direction
   typedef logic [1:0] bp_cnt_t;

   localparam bp_cnt_t SNT = 2'd0;
   localparam bp_cnt_t WNT = 2'd1;
   localparam bp_cnt_t WT  = 2'd2;
   localparam bp_cnt_t ST  = 2'd3;

   typedef enum logic {
      GS_INIT = 1'b0,
      GS_RUN  = 1'b1
   } gshare_state_e;

   // Operation applied by the PHT write port to the addressed counter
   typedef enum logic [1:0] {
      PHT_OP_INIT = 2'd0,
      PHT_OP_INC  = 2'd1,
      PHT_OP_DEC  = 2'd2
   } pht_op_e;

   // Next counter value for a write-port operation (saturating at SNT/ST)
   function automatic bp_cnt_t pht_next(input bp_cnt_t cur, input pht_op_e op);
      bp_cnt_t nxt;
      nxt = cur;
      case (op)
         PHT_OP_INIT: nxt = WNT;
         PHT_OP_INC:  nxt = (cur == ST)  ? ST  : cur + 2'd1;
         PHT_OP_DEC:  nxt = (cur == SNT) ? SNT : cur - 2'd1;
         default:     nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: array of 2-bit counters with one combinational
// read port and one synchronous write port. The write port applies an
// operation (init / increment / decrement) to the addressed counter.
// Optional macro GSHARE_UPDATE_BYPASS_EN: a read colliding with the write
// in the same cycle returns the post-update value instead of the old one.
module gshare_pht
   import cpu_consts::*;
#(
   parameter int IDX_W = 10
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] rd_idx_i,
   output bp_cnt_t          rd_cnt_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  pht_op_e          wr_op_i
);

   // Contents are established by the predictor's INIT sweep, so no reset
   bp_cnt_t mem_q [2**IDX_W];
   bp_cnt_t wr_new;

   // Compute the counter value the write port will store
   always_comb begin
      wr_new = pht_next(mem_q[wr_idx_i], wr_op_i);
   end

   // Synchronous write port
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_new;
      end
   end

   // Combinational read port, optionally forwarding a same-cycle update
   always_comb begin
      rd_cnt_o = mem_q[rd_idx_i];
`ifdef GSHARE_UPDATE_BYPASS_EN
      if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
         rd_cnt_o = wr_new;
      end
`endif
   end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor. After reset an INIT sweep writes
// weakly-not-taken into every PHT entry, then RUN serves predictions and
// resolves. Optional macro GSHARE_UPDATE_BYPASS_EN (handled in gshare_pht)
// makes a prediction colliding with a same-cycle resolve see the new count.
//
// Handshake: a request is accepted in a cycle where pred_req_i and
// pred_ready_o are both 1 and no mispredict is being resolved; the
// prediction appears for exactly one cycle with pred_valid_o = 1 in the
// following cycle. There is no back-pressure on the prediction output.
module gshare_predictor
   import cpu_consts::*;
#(
   parameter int GHR_W     = 10,  // must be >= 2 and <= PHT_IDX_W
   parameter int PHT_IDX_W = 10,
   parameter int PC_LSB    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pred_req_i,
   input  logic [63:0]      pc_i,
   output logic             pred_ready_o,
   output logic             pred_valid_o,
   output logic             pred_taken_o,
   output logic [GHR_W-1:0] pred_ghr_o,
   input  logic             resolve_valid_i,
   input  logic [63:0]      resolve_pc_i,
   input  logic [GHR_W-1:0] resolve_ghr_i,
   input  logic             resolve_taken_i,
   input  logic             resolve_mispredict_i,
   output logic [GHR_W-1:0] ghr_o,
   output gshare_state_e    dbg_state_o
);

   gshare_state_e          state_q, state_d;
   logic [PHT_IDX_W-1:0]   idx_cnt_q, idx_cnt_d;
   logic [GHR_W-1:0]       ghr_q, ghr_d;
   logic                   pred_valid_q, pred_valid_d;
   logic                   pred_taken_q, pred_taken_d;
   logic [GHR_W-1:0]       pred_ghr_q, pred_ghr_d;

   logic                   run;
   logic                   mispredict;
   logic                   accept;
   logic [GHR_W-1:0]       eff_ghr;
   logic [PHT_IDX_W-1:0]   pred_idx;
   logic [PHT_IDX_W-1:0]   res_idx;
   bp_cnt_t                rd_cnt;
   logic                   wr_en;
   logic [PHT_IDX_W-1:0]   wr_idx;
   pht_op_e                wr_op;
   logic                   unused_ok;

   // Only a slice of each PC and the top resolve-history bit feed indexing
   assign unused_ok = ^{pc_i, resolve_pc_i, resolve_ghr_i};

   // Index and handshake qualification; eff_ghr folds in a prediction
   // whose history shift has not landed in ghr_q yet
   always_comb begin
      run        = (state_q == GS_RUN);
      mispredict = run & resolve_valid_i & resolve_mispredict_i;
      eff_ghr    = pred_valid_q ? {ghr_q[GHR_W-2:0], pred_taken_q} : ghr_q;
      pred_idx   = pc_i[PC_LSB +: PHT_IDX_W] ^ PHT_IDX_W'(eff_ghr);
      res_idx    = resolve_pc_i[PC_LSB +: PHT_IDX_W] ^ PHT_IDX_W'(resolve_ghr_i);
      accept     = pred_req_i & run & ~mispredict;
   end

   // Shared write port: INIT sweep owns it, otherwise resolves update it
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = res_idx;
      wr_op  = PHT_OP_INIT;
      if (!run) begin
         wr_en  = 1'b1;
         wr_idx = idx_cnt_q;
         wr_op  = PHT_OP_INIT;
      end else if (resolve_valid_i) begin
         wr_en  = 1'b1;
         wr_idx = res_idx;
         wr_op  = resolve_taken_i ? PHT_OP_INC : PHT_OP_DEC;
      end
   end

   gshare_pht #(
      .IDX_W (PHT_IDX_W)
   ) u_pht (
      .clk      (clk),
      .rd_idx_i (pred_idx),
      .rd_cnt_o (rd_cnt),
      .wr_en_i  (wr_en),
      .wr_idx_i (wr_idx),
      .wr_op_i  (wr_op)
   );

   // FSM next state: sweep every PHT index once, then run forever
   always_comb begin
      state_d   = state_q;
      idx_cnt_d = idx_cnt_q;
      case (state_q)
         GS_INIT: begin
            idx_cnt_d = idx_cnt_q + PHT_IDX_W'(1);
            if (idx_cnt_q == '1) begin
               state_d = GS_RUN;
            end
         end
         GS_RUN:  state_d = GS_RUN;
         default: state_d = GS_INIT;
      endcase
   end

   // Prediction pipeline stage and speculative history update
   always_comb begin
      pred_valid_d = accept;
      pred_taken_d = accept & rd_cnt[1];
      pred_ghr_d   = accept ? eff_ghr : '0;
      ghr_d        = ghr_q;
      if (mispredict) begin
         ghr_d = {resolve_ghr_i[GHR_W-2:0], resolve_taken_i};
      end else if (pred_valid_q) begin
         ghr_d = {ghr_q[GHR_W-2:0], pred_taken_q};
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= GS_INIT;
         idx_cnt_q    <= '0;
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_ghr_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_cnt_q    <= idx_cnt_d;
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_ghr_q   <= pred_ghr_d;
      end
   end

   assign pred_ready_o = run;
   assign pred_valid_o = pred_valid_q;
   assign pred_taken_o = pred_taken_q;
   assign pred_ghr_o   = pred_ghr_q;
   assign ghr_o        = ghr_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed testbench for gshare_predictor (default parameters).
module tb_gshare_predictor;

   localparam int GHR_W = 10;
`ifdef GSHARE_UPDATE_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    pred_req_i;
   logic [63:0]             pc_i;
   logic                    pred_ready_o;
   logic                    pred_valid_o;
   logic                    pred_taken_o;
   logic [GHR_W-1:0]        pred_ghr_o;
   logic                    resolve_valid_i;
   logic [63:0]             resolve_pc_i;
   logic [GHR_W-1:0]        resolve_ghr_i;
   logic                    resolve_taken_i;
   logic                    resolve_mispredict_i;
   logic [GHR_W-1:0]        ghr_o;
   cpu_consts::gshare_state_e dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   gshare_predictor #(.GHR_W(10), .PHT_IDX_W(10), .PC_LSB(2)) dut (
      .clk                  (clk),
      .reset                (reset),
      .pred_req_i           (pred_req_i),
      .pc_i                 (pc_i),
      .pred_ready_o         (pred_ready_o),
      .pred_valid_o         (pred_valid_o),
      .pred_taken_o         (pred_taken_o),
      .pred_ghr_o           (pred_ghr_o),
      .resolve_valid_i      (resolve_valid_i),
      .resolve_pc_i         (resolve_pc_i),
      .resolve_ghr_i        (resolve_ghr_i),
      .resolve_taken_i      (resolve_taken_i),
      .resolve_mispredict_i (resolve_mispredict_i),
      .ghr_o                (ghr_o),
      .dbg_state_o          (dbg_state)
   );

   // Clock generation
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pred_req_i           = 1'b0;
      pc_i                 = 64'h0;
      resolve_valid_i      = 1'b0;
      resolve_pc_i         = 64'h0;
      resolve_ghr_i        = '0;
      resolve_taken_i      = 1'b0;
      resolve_mispredict_i = 1'b0;
   endtask

   task automatic drive_resolve(input logic [63:0] pc, input logic [GHR_W-1:0] ghr,
                                input logic taken, input logic misp);
      resolve_valid_i      = 1'b1;
      resolve_pc_i         = pc;
      resolve_ghr_i        = ghr;
      resolve_taken_i      = taken;
      resolve_mispredict_i = misp;
   endtask

   task automatic drive_req(input logic [63:0] pc);
      pred_req_i = 1'b1;
      pc_i       = pc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      n_checks++; if (pred_ready_o !== 1'b0) $display("FAIL reset_ready: got %0b expected 0", pred_ready_o); else n_pass++;
      n_checks++; if (pred_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", pred_valid_o); else n_pass++;
      n_checks++; if (pred_taken_o !== 1'b0) $display("FAIL reset_taken: got %0b expected 0", pred_taken_o); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h0) $display("FAIL reset_pred_ghr: got %0h expected 0", pred_ghr_o); else n_pass++;
      n_checks++; if (ghr_o !== 10'h0) $display("FAIL reset_ghr: got %0h expected 0", ghr_o); else n_pass++;
      n_checks++; if (dbg_state !== cpu_consts::GS_INIT) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
   endtask

   // Release reset and count not-ready cycles; a mispredict resolve
   // during the sweep must leave the history untouched
   task automatic test_init_sweep(input string tag);
      int cnt;
      reset = 1'b0;
      cnt = 0;
      while (!pred_ready_o && cnt < 2000) begin
         if (cnt == 5) drive_resolve(64'h1000, 10'h155, 1'b1, 1'b1);
         else idle();
         cnt++;
         tick();
         if (cnt == 6) begin
            n_checks++; if (ghr_o !== 10'h0) $display("FAIL %s_init_resolve_ignored: got %0h expected 0", tag, ghr_o); else n_pass++;
         end
      end
      idle();
      n_checks++; if (cnt != 1024) $display("FAIL %s_init_cycles: got %0d expected 1024", tag, cnt); else n_pass++;
   endtask

   task automatic test_first_predict(input string tag);
      drive_req(64'h1000);
      tick();
      idle();
      n_checks++; if (pred_valid_o !== 1'b1) $display("FAIL %s_first_valid: got %0b expected 1", tag, pred_valid_o); else n_pass++;
      n_checks++; if (pred_taken_o !== 1'b0) $display("FAIL %s_first_taken: got %0b expected 0", tag, pred_taken_o); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h0) $display("FAIL %s_first_pred_ghr: got %0h expected 0", tag, pred_ghr_o); else n_pass++;
      tick();
      n_checks++; if (pred_valid_o !== 1'b0) $display("FAIL %s_first_valid_drop: got %0b expected 0", tag, pred_valid_o); else n_pass++;
      n_checks++; if (ghr_o !== 10'h0) $display("FAIL %s_first_ghr: got %0h expected 0", tag, ghr_o); else n_pass++;
   endtask

   // Entry 0 goes 1 -> 2 -> 3 -> 3 -> 3, then decrements step it back down
   task automatic test_saturate();
      for (int i = 0; i < 4; i++) begin
         drive_resolve(64'h1000, 10'h0, 1'b1, 1'b0);
         tick();
      end
      idle();
      drive_req(64'h1000);
      tick();
      idle();
      n_checks++; if (pred_taken_o !== 1'b1) $display("FAIL sat_taken_at3: got %0b expected 1", pred_taken_o); else n_pass++;
      tick();
      n_checks++; if (ghr_o !== 10'h001) $display("FAIL sat_ghr_shift1: got %0h expected 1", ghr_o); else n_pass++;
      drive_resolve(64'h1000, 10'h0, 1'b0, 1'b0);
      tick();
      idle();
      drive_req(64'h1004);
      tick();
      idle();
      n_checks++; if (pred_taken_o !== 1'b1) $display("FAIL sat_taken_at2: got %0b expected 1", pred_taken_o); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h001) $display("FAIL sat_pred_ghr1: got %0h expected 1", pred_ghr_o); else n_pass++;
      tick();
      n_checks++; if (ghr_o !== 10'h003) $display("FAIL sat_ghr_shift2: got %0h expected 3", ghr_o); else n_pass++;
      drive_resolve(64'h1000, 10'h0, 1'b0, 1'b0);
      tick();
      idle();
      drive_req(64'h100C);
      tick();
      idle();
      n_checks++; if (pred_taken_o !== 1'b0) $display("FAIL sat_taken_at1: got %0b expected 0", pred_taken_o); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h003) $display("FAIL sat_pred_ghr3: got %0h expected 3", pred_ghr_o); else n_pass++;
      tick();
      n_checks++; if (ghr_o !== 10'h006) $display("FAIL sat_ghr_shift3: got %0h expected 6", ghr_o); else n_pass++;
   endtask

   task automatic test_back_to_back();
      drive_resolve(64'h1014, 10'h0, 1'b0, 1'b1);
      tick();
      n_checks++; if (ghr_o !== 10'h000) $display("FAIL b2b_ghr_clear: got %0h expected 0", ghr_o); else n_pass++;
      drive_resolve(64'h1000, 10'h0, 1'b1, 1'b0);
      tick();
      drive_resolve(64'h1004, 10'h0, 1'b1, 1'b0);
      tick();
      idle();
      drive_req(64'h1000);
      tick();
      n_checks++; if (pred_valid_o !== 1'b1) $display("FAIL b2b_valid0: got %0b expected 1", pred_valid_o); else n_pass++;
      n_checks++; if (pred_taken_o !== 1'b1) $display("FAIL b2b_taken0: got %0b expected 1", pred_taken_o); else n_pass++;
      n_checks++; if (pred_ready_o !== 1'b1) $display("FAIL b2b_ready: got %0b expected 1", pred_ready_o); else n_pass++;
      tick();
      idle();
      n_checks++; if (pred_valid_o !== 1'b1) $display("FAIL b2b_valid1: got %0b expected 1", pred_valid_o); else n_pass++;
      n_checks++; if (pred_taken_o !== 1'b1) $display("FAIL b2b_taken1: got %0b expected 1", pred_taken_o); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h001) $display("FAIL b2b_pred_ghr1: got %0h expected 1", pred_ghr_o); else n_pass++;
      n_checks++; if (ghr_o !== 10'h001) $display("FAIL b2b_ghr_mid: got %0h expected 1", ghr_o); else n_pass++;
      tick();
      n_checks++; if (ghr_o !== 10'h003) $display("FAIL b2b_ghr_final: got %0h expected 3", ghr_o); else n_pass++;
      n_checks++; if (pred_valid_o !== 1'b0) $display("FAIL b2b_valid_end: got %0b expected 0", pred_valid_o); else n_pass++;
   endtask

   // Mispredict lands on a cycle with a pending prediction and a new request
   task automatic test_mispredict();
      drive_req(64'h1000);
      tick();
      n_checks++; if (pred_taken_o !== 1'b0) $display("FAIL misp_pre_taken: got %0b expected 0", pred_taken_o); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h003) $display("FAIL misp_pre_pred_ghr: got %0h expected 3", pred_ghr_o); else n_pass++;
      drive_resolve(64'h1000, 10'h155, 1'b1, 1'b1);
      tick();
      idle();
      n_checks++; if (ghr_o !== 10'h2AB) $display("FAIL misp_ghr: got %0h expected 2ab", ghr_o); else n_pass++;
      n_checks++; if (pred_valid_o !== 1'b0) $display("FAIL misp_req_dropped: got %0b expected 0", pred_valid_o); else n_pass++;
   endtask

   task automatic test_collision();
      logic [GHR_W-1:0] exp_ghr;
      logic [GHR_W-1:0] idx_bits;
      logic [63:0]      pc;
      drive_resolve(64'h1000, 10'h2AB, 1'b1, 1'b0);
      drive_req(64'h1000);
      tick();
      idle();
      n_checks++; if (pred_valid_o !== 1'b1) $display("FAIL coll_valid: got %0b expected 1", pred_valid_o); else n_pass++;
      n_checks++; if (pred_taken_o !== BYP) $display("FAIL coll_taken: got %0b expected %0b", pred_taken_o, BYP); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h2AB) $display("FAIL coll_pred_ghr: got %0h expected 2ab", pred_ghr_o); else n_pass++;
      exp_ghr = BYP ? 10'h157 : 10'h156;
      tick();
      n_checks++; if (ghr_o !== exp_ghr) $display("FAIL coll_ghr: got %0h expected %0h", ghr_o, exp_ghr); else n_pass++;
      idx_bits = 10'h2AB ^ exp_ghr;
      pc = 64'h1000 | ({54'h0, idx_bits} << 2);
      drive_req(pc);
      tick();
      idle();
      n_checks++; if (pred_taken_o !== 1'b1) $display("FAIL coll_after_update: got %0b expected 1", pred_taken_o); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      drive_req(64'h1000);
      tick();
      idle();
      n_checks++; if (pred_valid_o !== 1'b1) $display("FAIL mid_valid_before: got %0b expected 1", pred_valid_o); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (pred_valid_o !== 1'b0) $display("FAIL mid_valid: got %0b expected 0", pred_valid_o); else n_pass++;
      n_checks++; if (pred_ready_o !== 1'b0) $display("FAIL mid_ready: got %0b expected 0", pred_ready_o); else n_pass++;
      n_checks++; if (pred_ghr_o !== 10'h0) $display("FAIL mid_pred_ghr: got %0h expected 0", pred_ghr_o); else n_pass++;
      n_checks++; if (ghr_o !== 10'h0) $display("FAIL mid_ghr: got %0h expected 0", ghr_o); else n_pass++;
      n_checks++; if (dbg_state !== cpu_consts::GS_INIT) $display("FAIL mid_state: got %0d expected 0", dbg_state); else n_pass++;
      tick();
      tick();
      test_init_sweep("mid");
      test_first_predict("mid");
   endtask

   initial begin
      idle();
      test_reset();
      test_init_sweep("por");
      test_first_predict("por");
      test_saturate();
      test_back_to_back();
      test_mispredict();
      test_collision();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter GHR_W, default 10, global history length in bits.
REQ-002 SHALL have parameter PHT_IDX_W, default 10, log2 of PHT entry count; GHR_W <= PHT_IDX_W is required.
REQ-003 SHALL have parameter PC_LSB, default 2, lowest PC bit used for indexing.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports in order: clk input 1 (rising-edge clock), reset input 1 (asynchronous active-high reset).
REQ-005 SHALL have ports: pred_req_i input 1, prediction request; pc_i input 64, fetch PC.
REQ-006 SHALL have ports: pred_ready_o output 1, block accepts requests; pred_valid_o output 1, prediction valid; pred_taken_o output 1, predicted direction; pred_ghr_o output GHR_W, history used for this prediction.
REQ-007 SHALL have ports: resolve_valid_i input 1; resolve_pc_i input 64; resolve_ghr_i input GHR_W (pred_ghr_o returned by the pipeline); resolve_taken_i input 1; resolve_mispredict_i input 1.
REQ-008 SHALL have port ghr_o output GHR_W, current speculative history.

Function
REQ-009 SHALL implement a two-state FSM, INIT and RUN; pred_ready_o = 1 only in RUN.
REQ-010 In INIT, SHALL write weakly-not-taken (2'b01) to PHT entry idx_cnt each cycle, idx_cnt counting 0 to 2^PHT_IDX_W-1, then enter RUN on the following cycle.
REQ-011 SHALL define eff_ghr = pred_valid_o ? {ghr[GHR_W-2:0], pred_taken_o} : ghr.
REQ-012 Prediction index SHALL be pc_i[PC_LSB +: PHT_IDX_W] XOR zero-extended eff_ghr; resolve index SHALL be resolve_pc_i[PC_LSB +: PHT_IDX_W] XOR zero-extended resolve_ghr_i.
REQ-013 A request accepted in cycle N (pred_req_i & pred_ready_o) SHALL produce, in cycle N+1, pred_valid_o = 1, pred_taken_o = counter[1], and pred_ghr_o = eff_ghr sampled in cycle N.
REQ-014 When pred_valid_o = 1 and no mispredict is present, SHALL load ghr <= {ghr[GHR_W-2:0], pred_taken_o} at the clock edge.
REQ-015 When resolve_valid_i = 1 in RUN, SHALL saturate the indexed counter: increment toward 3 if resolve_taken_i, else decrement toward 0.
REQ-016 When resolve_valid_i & resolve_mispredict_i, SHALL load ghr <= {resolve_ghr_i[GHR_W-2:0], resolve_taken_i}; this takes priority over REQ-014.
REQ-017 A request presented in a mispredict cycle SHALL be dropped: pred_valid_o = 0 in the next cycle.
REQ-018 resolve_valid_i in INIT SHALL be ignored, with no PHT or ghr change.
REQ-019 Back-to-back requests SHALL be accepted every cycle in RUN.

Reset
REQ-020 Reset SHALL force state INIT, idx_cnt = 0, ghr = 0, pred_valid_o = 0, pred_taken_o = 0, pred_ghr_o = 0, and pred_ready_o = 0.
REQ-021 Reset asserted mid-operation SHALL abandon any in-flight prediction and restart the INIT sweep from index 0.

Configuration
REQ-022 Macro GSHARE_UPDATE_BYPASS_EN: when defined, a prediction read that hits the index being updated in the same cycle SHALL return the post-update counter.
REQ-023 Without GSHARE_UPDATE_BYPASS_EN, such a colliding read SHALL return the pre-update counter.

Structure
REQ-024 SHALL take bp_cnt_t (2-bit counter), counter constants (SNT = 0, WNT = 1, WT = 2, ST = 3), and the gshare FSM state enum from the shared cpu_consts package.
REQ-025 SHALL place the counter array in sub-module gshare_pht, which has one combinational read port and one synchronous write port; the INIT write and the resolve write share that write port.

Verification
REQ-026 Reset release, GHR_W = 10, PHT_IDX_W = 10 -> pred_ready_o = 0 for exactly 1024 cycles, then 1; first prediction at pc 0x1000 gives pred_taken_o = 0.
REQ-027 Three resolves, taken, at pc 0x1000 with ghr 0 -> counter reaches 3 and stays 3 after a fourth resolve; a prediction with ghr 0 returns taken.
REQ-028 Back-to-back requests in cycles N and N+1, first predicted taken -> second prediction's pred_ghr_o = 0x001, and ghr_o = 0x003 after both if both are taken.
REQ-029 Mispredict with resolve_ghr_i = 0x155 and resolve_taken_i = 1, together with a concurrent request -> ghr_o = 0x2AB next cycle, and pred_valid_o = 0 next cycle.
REQ-030 Resolve taken and predict to the same index in one cycle, counter at 1 -> pred_taken_o = 1 with GSHARE_UPDATE_BYPASS_EN defined, 0 without it.
REQ-031 Reset asserted in RUN with pred_valid_o = 1 -> all outputs 0 immediately; the INIT sweep restarts and lasts the full 1024 cycles.
